// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed 7-segment scanner with dead time, blinking and leading-zero blanking.
// Inputs are captured once per frame so a frame never mixes old and new values.
module seg_scan_driver #(
  parameter int IN_CLK_HZ = 50_000_000,
  parameter int SCAN_HZ   = 1000,
  parameter int DEAD_CYC  = 16,
  parameter int BLINK_HZ  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit_0,
  input  logic [3:0] digit_1,
  input  logic [3:0] digit_2,
  input  logic [3:0] digit_3,
  input  logic [3:0] dp_in,
  input  logic [3:0] blink_mask,
  input  logic       blank_lz,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic [3:0] an_n,
  output logic       frame_tick
);

  localparam int TICK_DIV   = IN_CLK_HZ / SCAN_HZ;
  localparam int BLINK_HALF = IN_CLK_HZ / (2 * BLINK_HZ);
  localparam int SC_W       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BC_W       = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [SC_W-1:0] SC_LAST = SC_W'(TICK_DIV - 1);
  localparam logic [SC_W-1:0] SC_DEAD = SC_W'(DEAD_CYC);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLINK_HALF - 1);

  logic [SC_W-1:0] sc;
  logic [1:0]      idx;
  logic [BC_W-1:0] blink_cnt;
  logic            blink_phase;

  logic [3:0][3:0] sh_digit;
  logic [3:0]      sh_dp;
  logic [3:0]      sh_mask;
  logic            sh_lz;

  logic            load;
  logic [3:0]      lz_blank;
  logic [3:0]      cur_digit;
  logic [6:0]      seg_code;
  logic [6:0]      seg_next;
  logic            dp_next;
  logic [3:0]      an_next;

  assign load       = (sc == '0) && (idx == 2'd0) && !rst;
  assign frame_tick = load;

  always_ff @(posedge clk) begin
    if (rst) begin
      sc          <= '0;
      idx         <= 2'd0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      if (sc == SC_LAST) begin
        sc  <= '0;
        idx <= idx + 2'd1;
      end else begin
        sc <= sc + SC_W'(1);
      end
      if (blink_cnt == BC_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_digit <= '0;
      sh_dp    <= 4'd0;
      sh_mask  <= 4'd0;
      sh_lz    <= 1'b0;
    end else if (load) begin
      sh_digit <= {digit_3, digit_2, digit_1, digit_0};
      sh_dp    <= dp_in;
      sh_mask  <= blink_mask;
      sh_lz    <= blank_lz;
    end
  end

  // A digit is a leading zero only if every digit to its left is one too.
  always_comb begin
    lz_blank    = 4'd0;
    lz_blank[3] = sh_lz && (sh_digit[3] == 4'd0);
    lz_blank[2] = lz_blank[3] && (sh_digit[2] == 4'd0);
    lz_blank[1] = lz_blank[2] && (sh_digit[1] == 4'd0);
  end

  assign cur_digit = sh_digit[idx];

  always_comb begin
    case (cur_digit)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0010000;
      default: seg_code = 7'b0111111;
    endcase
  end

  // Blink blanking kills the decimal point too; leading-zero blanking does not.
  always_comb begin
    seg_next = 7'h7F;
    dp_next  = 1'b1;
    an_next  = 4'hF;
    if (sc >= SC_DEAD) begin
      an_next = ~(4'b0001 << idx);
      if (blink_phase && sh_mask[idx]) begin
        seg_next = 7'h7F;
        dp_next  = 1'b1;
      end else begin
        seg_next = lz_blank[idx] ? 7'h7F : seg_code;
        dp_next  = ~sh_dp[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_n <= 7'h7F;
      dp_n  <= 1'b1;
      an_n  <= 4'hF;
    end else begin
      seg_n <= seg_next;
      dp_n  <= dp_next;
      an_n  <= an_next;
    end
  end

endmodule
